// File: rtl/reqrsp_buffer_if.sv
// ============================================================================
// Module   : reqrsp_if
// Purpose  : reqrsp handshake bundle (q request channel, p response channel)
// Revision : 1.0
// ============================================================================
`default_nettype none

interface reqrsp_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
) ();
    logic [AddrWidth-1:0]   q_addr;
    logic                   q_write;
    logic [DataWidth-1:0]   q_data;
    logic [DataWidth/8-1:0] q_strb;
    logic                   q_valid;
    logic                   q_ready;
    logic [DataWidth-1:0]   p_data;
    logic                   p_error;
    logic                   p_valid;
    logic                   p_ready;

    modport master (
        output q_addr, q_write, q_data, q_strb, q_valid, p_ready,
        input  q_ready, p_data, p_error, p_valid
    );

    modport slave (
        input  q_addr, q_write, q_data, q_strb, q_valid, p_ready,
        output q_ready, p_data, p_error, p_valid
    );
endinterface

`default_nettype wire

// File: rtl/reqrsp_buffer.sv
// ============================================================================
// Module   : reqrsp_buffer
// Purpose  : req/rsp FIFOs plus outstanding-credit gate; optional stall
//            counter enabled by REQRSP_BUFFER_STATS_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module reqrsp_buffer_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 8
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    input  wire logic             in_valid_i,
    output logic                  in_ready_o,
    input  wire logic [Width-1:0] in_data_i,
    output logic                  out_valid_o,
    input  wire logic             out_ready_i,
    output logic      [Width-1:0] out_data_o
);
    generate
        if (Depth == 0) begin : g_pass
            logic unused_pass;
            assign unused_pass = clk_i ^ rst_ni;
            assign in_ready_o  = out_ready_i;
            assign out_valid_o = in_valid_i;
            assign out_data_o  = in_data_i;
        end else begin : g_fifo
            localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
            localparam int unsigned CntW = $clog2(Depth + 1);

            logic [Width-1:0] mem_q [Depth];
            logic [Width-1:0] mem_d [Depth];
            logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
            logic [CntW-1:0]  count_q, count_d;
            logic             push, pop, full, empty;

            // Ready looks only at fill level, so a full FIFO refuses a push even while popping.
            assign full        = (count_q == CntW'(Depth));
            assign empty       = (count_q == '0);
            assign push        = in_valid_i && !full;
            assign pop         = out_ready_i && !empty;
            assign in_ready_o  = !full;
            assign out_valid_o = !empty;
            assign out_data_o  = mem_q[rd_ptr_q];

            always_comb begin
                mem_d    = mem_q;
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                count_d  = count_q;
                if (push) begin
                    mem_d[wr_ptr_q] = in_data_i;
                    wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    mem_q    <= '{default: '0};
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    mem_q    <= mem_d;
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                end
            end
        end
    endgenerate
endmodule

module reqrsp_buffer #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned ReqDepth       = 2,
    parameter int unsigned RspDepth       = 2,
    parameter int unsigned MaxOutstanding = 4
) (
    input  wire logic                                  clk_i,
    input  wire logic                                  rst_ni,
    reqrsp_if.slave                                    slv,
    reqrsp_if.master                                   mst,
    output logic [$clog2(MaxOutstanding+1)-1:0]        outstanding_o,
    output logic                                       busy_o
`ifdef REQRSP_BUFFER_STATS_EN
    ,
    output logic [31:0]                                stall_cnt_o
`endif
);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned QW   = AddrWidth + 1 + DataWidth + DataWidth / 8;
    localparam int unsigned PW   = DataWidth + 1;

    logic [QW-1:0]   req_in, req_out;
    logic [PW-1:0]   rsp_in, rsp_out;
    logic            req_pending, req_pop_ready, credit_ok;
    logic            q_fire, p_fire;
    logic [CntW-1:0] outstanding_q, outstanding_d;

    assign req_in = {slv.q_addr, slv.q_write, slv.q_data, slv.q_strb};

    reqrsp_buffer_fifo #(.Depth(ReqDepth), .Width(QW)) u_req_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_valid_i (slv.q_valid),
        .in_ready_o (slv.q_ready),
        .in_data_i  (req_in),
        .out_valid_o(req_pending),
        .out_ready_i(req_pop_ready),
        .out_data_o (req_out)
    );

    // The head entry stays in the FIFO while the credit gate is closed.
    assign credit_ok     = (outstanding_q < CntW'(MaxOutstanding));
    assign mst.q_valid   = req_pending && credit_ok;
    assign req_pop_ready = mst.q_ready && credit_ok;
    assign {mst.q_addr, mst.q_write, mst.q_data, mst.q_strb} = req_out;

    assign rsp_in = {mst.p_data, mst.p_error};

    reqrsp_buffer_fifo #(.Depth(RspDepth), .Width(PW)) u_rsp_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_valid_i (mst.p_valid),
        .in_ready_o (mst.p_ready),
        .in_data_i  (rsp_in),
        .out_valid_o(slv.p_valid),
        .out_ready_i(slv.p_ready),
        .out_data_o (rsp_out)
    );

    assign {slv.p_data, slv.p_error} = rsp_out;

    assign q_fire = mst.q_valid && mst.q_ready;
    assign p_fire = slv.p_valid && slv.p_ready;

    always_comb begin
        outstanding_d = outstanding_q;
        case ({q_fire, p_fire && (outstanding_q != '0)})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) outstanding_q <= '0;
        else         outstanding_q <= outstanding_d;
    end

    assign outstanding_o = outstanding_q;
    // Pass-through channels hold no data, so they never count as buffered.
    assign busy_o = ((ReqDepth != 0) && req_pending) ||
                    ((RspDepth != 0) && slv.p_valid) ||
                    (outstanding_q != '0);

`ifdef REQRSP_BUFFER_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (req_pending && !credit_ok && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stall_cnt_q <= '0;
        else         stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(p_fire && (outstanding_q == '0)))
                else $error("reqrsp_buffer: response delivered with no request outstanding");
        end
    end
`endif
endmodule

`default_nettype wire

// File: doc/reqrsp_buffer.md
Name: reqrsp_buffer

Overview:
Single-clock, parametrised buffering and flow-control stage for the reqrsp interface. It places a configurable-depth FIFO on the request (q) channel and another on the response (p) channel. It also enforces a hard limit on transactions outstanding downstream. It sits between a reqrsp master (core, DMA, cluster port) and a slave or interconnect, for timing cuts, decoupling and credit limiting in one block.

Parameters:
AddrWidth, 32, address width of q channel.
DataWidth, 32, data width; strobe width is DataWidth/8.
req_t, logic, reqrsp request struct (q, q_valid, p_ready).
rsp_t, logic, reqrsp response struct (p, p_valid, q_ready).
ReqDepth, 2, request FIFO depth; 0 = combinational pass-through.
RspDepth, 2, response FIFO depth; 0 = combinational pass-through.
MaxOutstanding, 4, maximum requests accepted downstream without a response delivered upstream; must be >= 1.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  asynchronous active-low reset.
slv_req_i  in  req_t  upstream request.
slv_rsp_o  out  rsp_t  upstream response.
mst_req_o  out  req_t  downstream request.
mst_rsp_i  in  rsp_t  downstream response.
outstanding_o  out  $clog2(MaxOutstanding+1)  current outstanding count.
busy_o  out  1  high when any FIFO is non-empty or outstanding_o != 0.

Behaviour:
- One clock: clk_i. Reset: rst_ni, asynchronous assert, active-low.
- All state registers use async reset. After reset: FIFOs empty, counter 0, slv_rsp_o.p_valid=0, mst_req_o.q_valid=0, outstanding_o=0, busy_o=0.
- Handshake rules (both channels, both sides):
  - Transfer occurs when valid&&ready on the rising edge.
  - Once asserted, valid and payload stay stable until the transfer.
  - Valid never depends combinationally on ready of the same channel.
- Request FIFO (ReqDepth>=1):
  - No fall-through: an entry pushed at cycle N is visible on mst_req_o at N+1 at the earliest.
  - slv_rsp_o.q_ready = !full. It depends only on fill level: no push when full, even if popping in the same cycle.
  - ReqDepth=1 therefore sustains 1 transfer per 2 cycles. ReqDepth>=2 sustains 1 transfer per cycle.
- Response FIFO (RspDepth>=1): same rules, mst_req_o.p_ready = !full.
- Depth 0: channel is wired combinationally (valid, ready, payload); zero latency.
- Credit gate:
  - mst_req_o.q_valid = req FIFO not empty && (outstanding < MaxOutstanding).
  - At the limit, the request waits in the FIFO; the payload is held and not dropped.
- Counter:
  - +1 on downstream q transfer (mst_req_o.q_valid && mst_rsp_i.q_ready).
  - -1 on upstream p transfer (slv_rsp_o.p_valid && slv_req_i.p_ready).
  - Both events in the same cycle: counter unchanged.
  - The counter never exceeds MaxOutstanding and never underflows.
  - A p transfer with count 0 is a protocol error and is flagged by an assertion in simulation.
- Ordering: strict in-order per channel; no reordering and no ID handling.
- Gated request release: a gated request is released in the cycle after a decrement makes outstanding < MaxOutstanding.
- Reset mid-operation: buffered requests, responses and credits are discarded immediately; outputs return to reset values asynchronously. Downstream must be reset in the same domain.

Optional Feature:
REQRSP_BUFFER_STATS_EN:
- Defined: adds port stall_cnt_o (out, 32 bits). It is a saturating count of cycles where the req FIFO is non-empty but q_valid is gated by the credit limit. Reset value 0; holds at 2^32-1 on saturation.
- Undefined: the port and counter are absent and there is no area cost.

Test Plan:
- Reset, then 8 back-to-back writes at addr 0x100..0x11C with ReqDepth=2 and downstream always ready: each appears on mst_req_o exactly 1 cycle after acceptance, 1 per cycle, same order and data.
- MaxOutstanding=4, downstream never responds, 6 requests issued: exactly 4 downstream transfers; outstanding_o=4; requests 5 and 6 held in the FIFO and slv_rsp_o.q_ready drops after the FIFO fills.
- From the limit above, one response delivered with slv p_ready=1: outstanding_o goes 4 to 3, and request 5 is released the following cycle.
- Same-cycle downstream q transfer and upstream p transfer with outstanding_o=2: outstanding_o stays 2.
- ReqDepth=0, RspDepth=0: request and response pass combinationally with 0-cycle latency; credit limit still enforced at MaxOutstanding.
- rst_ni pulsed low with 2 requests buffered and 3 outstanding: outputs clear asynchronously; after release outstanding_o=0, busy_o=0, and no stale request appears. With REQRSP_BUFFER_STATS_EN, stall_cnt_o=0 after reset.
